// File: rtl/doodle_y.sv
// Vertical-motion engine for the doodle sprite: integrates jump and gravity into d_y once per
// game tick, snaps onto platforms when falling through their top row, and latches game over at the floor.
module doodle_y #(
  parameter int VBP      = 31,
  parameter int BOTTOM   = 511,
  parameter int RESET_Y  = 400,
  parameter int D_W      = 20,
  parameter int D_H      = 20,
  parameter int P_WIDTH  = 75,
  parameter int JUMP_V   = 12,
  parameter int MAX_FALL = 8,
  parameter int G_DIV    = 4
) (
  input  logic       doodle_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] d_x,
  input  logic [9:0] p1_hpos,
  input  logic [9:0] p2_hpos,
  input  logic [9:0] p3_hpos,
  input  logic [9:0] p1_vpos,
  input  logic [9:0] p2_vpos,
  input  logic [9:0] p3_vpos,
  output logic [9:0] d_y,
  output logic       falling,
  output logic       land,
  output logic       dead
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam int            GW     = (G_DIV > 2) ? $clog2(G_DIV) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(G_DIV - 1);
  localparam logic [3:0]    JV     = 4'(JUMP_V);
  localparam logic [3:0]    MF     = 4'(MAX_FALL);
  localparam logic [10:0]   VBP_W  = 11'(VBP);
  localparam logic [10:0]   BOT_W  = 11'(BOTTOM);
  localparam logic [10:0]   DH_W   = 11'(D_H);
  localparam logic [10:0]   DW_W   = 11'(D_W);
  localparam logic [10:0]   PW_W   = 11'(P_WIDTH);
  localparam logic [9:0]    FLOOR_Y = 10'(BOTTOM - D_H);

  logic [1:0]    state;
  logic [3:0]    vel;
  logic [GW-1:0] gcnt;

  // All position arithmetic is 11 bits so sums near the bottom edge never wrap.
  function automatic logic on_plat(input logic [10:0] feet, input logic [10:0] nfeet,
                                   input logic [10:0] x, input logic [10:0] hpos,
                                   input logic [10:0] vpos);
    return (feet <= vpos) && (nfeet >= vpos) && ((x + DW_W) > hpos) && (x < (hpos + PW_W));
  endfunction

  function automatic logic [3:0] vel_sat_inc(input logic [3:0] v);
    return (v >= MF) ? MF : v + 4'd1;
  endfunction

  function automatic logic [10:0] ceil_clamp(input logic [10:0] y);
    return (y < VBP_W) ? VBP_W : y;
  endfunction

  logic [10:0] y_w, vel_w, x_w, rise_y, fall_y, feet, next_feet, land_row, snap_y;
  logic        hit1, hit2, hit3, any_hit;

  assign y_w       = {1'b0, d_y};
  assign vel_w     = {7'd0, vel};
  assign x_w       = {1'b0, d_x};
  assign rise_y    = ceil_clamp(y_w - vel_w);
  assign fall_y    = y_w + vel_w;
  assign feet      = y_w + DH_W;
  assign next_feet = fall_y + DH_W;

  assign hit1    = on_plat(feet, next_feet, x_w, {1'b0, p1_hpos}, {1'b0, p1_vpos});
  assign hit2    = on_plat(feet, next_feet, x_w, {1'b0, p2_hpos}, {1'b0, p2_vpos});
  assign hit3    = on_plat(feet, next_feet, x_w, {1'b0, p3_hpos}, {1'b0, p3_vpos});
  assign any_hit = hit1 | hit2 | hit3;

  // Lowest-numbered platform wins when several are crossed in the same tick.
  always_comb begin
    land_row = 11'd0;
    if (hit1)      land_row = {1'b0, p1_vpos};
    else if (hit2) land_row = {1'b0, p2_vpos};
    else if (hit3) land_row = {1'b0, p3_vpos};
  end

  assign snap_y = land_row - DH_W;

  always_ff @(posedge doodle_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      d_y   <= 10'(RESET_Y);
      vel   <= 4'd0;
      gcnt  <= '0;
      land  <= 1'b0;
    end else begin
      land <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RISE;
            vel   <= JV;
            gcnt  <= '0;
          end
        end
        S_RISE: begin
          d_y <= 10'(rise_y);
          if (gcnt == G_LAST) begin
            gcnt <= '0;
            if (vel == 4'd1) state <= S_FALL;
            else             vel   <= vel - 4'd1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_FALL: begin
          if (any_hit) begin
            d_y   <= 10'(snap_y);
            vel   <= JV;
            gcnt  <= '0;
            state <= S_RISE;
            land  <= 1'b1;
          end else if (next_feet >= BOT_W) begin
            d_y   <= FLOOR_Y;
            state <= S_DEAD;
          end else begin
            d_y <= 10'(fall_y);
            if (gcnt == G_LAST) begin
              gcnt <= '0;
              vel  <= vel_sat_inc(vel);
            end else begin
              gcnt <= gcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign falling = (state == S_FALL);
  assign dead    = (state == S_DEAD);

endmodule

// File: tb/tb_doodle_y.sv
// Directed bench for doodle_y: a tick-level reference model pushes expected outputs to a
// scoreboard queue as stimulus is applied; entries are popped and compared after each edge.
module tb_doodle_y;

  logic       doodle_clk = 1'b0;
  logic       rst, rst2, start, start2;
  logic [9:0] d_x, p1_hpos, p2_hpos, p3_hpos, p1_vpos, p2_vpos, p3_vpos;
  logic [9:0] d_y, d_y2;
  logic       falling, land, dead, falling2, land2, dead2;

  always #5 doodle_clk = ~doodle_clk;

  doodle_y dut (
    .doodle_clk(doodle_clk), .rst(rst), .start(start), .d_x(d_x),
    .p1_hpos(p1_hpos), .p2_hpos(p2_hpos), .p3_hpos(p3_hpos),
    .p1_vpos(p1_vpos), .p2_vpos(p2_vpos), .p3_vpos(p3_vpos),
    .d_y(d_y), .falling(falling), .land(land), .dead(dead)
  );

  doodle_y #(.RESET_Y(60)) dut2 (
    .doodle_clk(doodle_clk), .rst(rst2), .start(start2), .d_x(d_x),
    .p1_hpos(p1_hpos), .p2_hpos(p2_hpos), .p3_hpos(p3_hpos),
    .p1_vpos(p1_vpos), .p2_vpos(p2_vpos), .p3_vpos(p3_vpos),
    .d_y(d_y2), .falling(falling2), .land(land2), .dead(dead2)
  );

  typedef struct packed {
    logic [9:0] y;
    logic       f;
    logic       l;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: 0 idle, 1 rise, 2 fall, 3 dead
  int m_st, m_y, m_vel, m_g;
  bit m_land;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic model_reset(input int ry);
    m_st = 0; m_y = ry; m_vel = 0; m_g = 0; m_land = 0;
  endtask

  task automatic model_step();
    int ny, feet, nf, x;
    int ph[3];
    int pv[3];
    bit done;
    ph[0] = int'(p1_hpos); ph[1] = int'(p2_hpos); ph[2] = int'(p3_hpos);
    pv[0] = int'(p1_vpos); pv[1] = int'(p2_vpos); pv[2] = int'(p3_vpos);
    x = int'(d_x);
    m_land = 0;
    case (m_st)
      0: if (start) begin m_st = 1; m_vel = 12; m_g = 0; end
      1: begin
        ny = m_y - m_vel;
        m_y = (ny < 31) ? 31 : ny;
        if (m_g == 3) begin
          m_g = 0;
          if (m_vel == 1) m_st = 2;
          else m_vel = m_vel - 1;
        end else m_g = m_g + 1;
      end
      2: begin
        ny = m_y + m_vel;
        feet = m_y + 20;
        nf = ny + 20;
        done = 0;
        for (int i = 0; i < 3; i++) begin
          if (!done && feet <= pv[i] && nf >= pv[i] && x + 20 > ph[i] && x < ph[i] + 75) begin
            done = 1; m_y = pv[i] - 20; m_vel = 12; m_g = 0; m_st = 1; m_land = 1;
          end
        end
        if (!done) begin
          if (nf >= 511) begin
            m_st = 3; m_y = 491;
          end else begin
            m_y = ny;
            if (m_g == 3) begin
              m_g = 0;
              if (m_vel < 8) m_vel = m_vel + 1;
            end else m_g = m_g + 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.y = 10'(m_y);
    e.f = (m_st == 2);
    e.l = m_land;
    e.d = (m_st == 3);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_y"},       d_y,            e.y);
      check({tag, "_falling"}, 10'(falling),   10'(e.f));
      check({tag, "_land"},    10'(land),      10'(e.l));
      check({tag, "_dead"},    10'(dead),      10'(e.d));
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    push_exp();
    @(posedge doodle_clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic do_reset();
    @(negedge doodle_clk);
    rst = 1'b1;
    #1;
    model_reset(400);
    push_exp();
    pop_cmp("rst");
    rst = 1'b0;
  endtask

  task automatic set_plats(input int h1, input int v1, input int h2, input int v2,
                           input int h3, input int v3);
    p1_hpos = 10'(h1); p1_vpos = 10'(v1);
    p2_hpos = 10'(h2); p2_vpos = 10'(v2);
    p3_hpos = 10'(h3); p3_vpos = 10'(v3);
  endtask

  // Launch from reset and run until the model lands or dies, then check the outcome.
  task automatic run_case(input string tag, input int want_land, input int want_y);
    int n;
    do_reset();
    start = 1'b1;
    tick(tag);
    start = 1'b0;
    n = 0;
    while (!m_land && m_st != 3 && n < 300) begin
      tick(tag);
      n++;
    end
    check({tag, "_land_end"}, 10'(land), 10'(want_land));
    check({tag, "_y_end"},    d_y,       10'(want_y));
  endtask

  initial begin
    int n;
    int rise_exp[5];
    int want2;
    rise_exp = '{388, 376, 364, 352, 341};
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    d_x = 10'd0;
    set_plats(0, 0, 0, 0, 0, 0);
    #2;
    model_reset(400);
    push_exp();
    pop_cmp("reset");
    check("reset_y2", d_y2, 10'd60);
    @(negedge doodle_clk);
    rst = 1'b0; rst2 = 1'b0;

    repeat (10) tick("idle");
    check("idle_y", d_y, 10'd400);

    // Full rise from rest, platforms out of reach
    start = 1'b1;
    tick("start");
    start = 1'b0;
    check("start_hold_y", d_y, 10'd400);
    for (int k = 1; k <= 48; k++) begin
      tick("rise");
      if (k <= 5) check("rise_k", d_y, 10'(rise_exp[k-1]));
    end
    check("apex_y", d_y, 10'd88);
    tick("fall1");
    check("fall1_y", d_y, 10'd89);
    check("fall1_falling", 10'(falling), 10'd1);

    n = 0;
    while (m_st != 3 && n < 200) begin
      tick("fall");
      n++;
    end
    check("dead_y", d_y, 10'd491);
    check("dead_flag", 10'(dead), 10'd1);
    repeat (3) tick("dead_hold");
    check("dead_hold_y", d_y, 10'd491);

    // Landing on p1 and the following bounce tick
    d_x = 10'd400;
    set_plats(380, 300, 0, 0, 0, 0);
    run_case("land_p1", 1, 280);
    tick("bounce");
    check("bounce_y", d_y, 10'd268);
    check("bounce_land", 10'(land), 10'd0);

    set_plats(421, 300, 0, 0, 0, 0);
    run_case("no_overlap_l", 0, 491);
    set_plats(419, 300, 0, 0, 0, 0);
    run_case("edge_l", 1, 280);
    set_plats(325, 300, 0, 0, 0, 0);
    run_case("no_overlap_r", 0, 491);
    set_plats(326, 300, 0, 0, 0, 0);
    run_case("edge_r", 1, 280);
    set_plats(380, 298, 390, 300, 0, 0);
    run_case("prio_p1", 1, 278);
    set_plats(380, 300, 390, 300, 0, 0);
    run_case("prio_same", 1, 280);
    set_plats(0, 0, 0, 0, 380, 300);
    run_case("p3_only", 1, 280);

    // Ceiling clamp and async reset on the RESET_Y=60 instance
    rst = 1'b1;
    set_plats(0, 0, 0, 0, 0, 0);
    start2 = 1'b1;
    @(posedge doodle_clk);
    #1;
    start2 = 1'b0;
    check("ceil_start_y", d_y2, 10'd60);
    for (int k = 1; k <= 48; k++) begin
      @(posedge doodle_clk);
      #1;
      want2 = (k == 1) ? 48 : (k == 2) ? 36 : 31;
      check("ceil_y", d_y2, 10'(want2));
      if (k < 48) check("ceil_falling", 10'(falling2), 10'd0);
    end
    repeat (3) @(posedge doodle_clk);
    #1;
    check("ceil_fall_y", d_y2, 10'd34);
    check("ceil_fall_flag", 10'(falling2), 10'd1);
    @(negedge doodle_clk);
    rst2 = 1'b1;
    #1;
    check("async_rst_y", d_y2, 10'd60);
    check("async_rst_falling", 10'(falling2), 10'd0);
    check("async_rst_land", 10'(land2), 10'd0);
    check("async_rst_dead", 10'(dead2), 10'd0);
    @(negedge doodle_clk);
    rst2 = 1'b0;
    @(posedge doodle_clk);
    #1;
    check("post_rst_idle_y", d_y2, 10'd60);
    check("sb_drained", 10'(sb.size()), 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
